mem_wb_stage: RTL

//  MEM stage plus MEM/WB register of the 5-stage pipeline: consumes the EX/MEM register outputs (M-suffixed),

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/data_mem.sv | 26 ++
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths and FSM state encoding for the MEM/WB stage.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int RFA_W  = 5;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write port, asynchronous read port.
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register with wait-state FSM.
// Optional misaligned-access trap enabled by defining DM_ALIGN_CHECK_EN.
module mem_wb_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RFWEM,
    input  logic              MtoRFSelM,
    input  logic              DMWEM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] DMdinM,
    input  logic [RFA_W-1:0]  RFAM,
    output logic              StallM,
    output logic              RFWEW,
    output logic              MtoRFSelW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] DMOutW,
    output logic [RFA_W-1:0]  RFAW,
    output logic              MisalignW
);

    localparam int AW = $clog2(DEPTH);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rfwe_w_q, rfwe_w_d;
    logic                mtorf_w_q, mtorf_w_d;
    logic [DATA_W-1:0]   alu_w_q, alu_w_d;
    logic [DATA_W-1:0]   dmout_w_q, dmout_w_d;
    logic [RFA_W-1:0]    rfa_w_q, rfa_w_d;
    logic                misalign_w_q, misalign_w_d;

    logic                access;
    logic                misalign;
    logic                stall;
    logic                mem_we;
    logic [AW-1:0]       word_idx;
    logic [DATA_W-1:0]   mem_rdata;

    assign word_idx = ALUOutM[AW+1:2];

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_idx),
        .wdata (DMdinM),
        .raddr (word_idx),
        .rdata (mem_rdata)
    );

    always_comb begin
        access = MtoRFSelM | DMWEM;
`ifdef DM_ALIGN_CHECK_EN
        misalign = access & (ALUOutM[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif

        stall   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (access && (WAIT_STATES > 0)) begin
                    stall   = 1'b1;
                    cnt_d   = CNT_W'(WAIT_STATES - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Gate the write with rst_n so a reset on the completion edge aborts the store.
        mem_we = DMWEM & ~stall & ~misalign & rst_n;

        rfwe_w_d     = rfwe_w_q;
        mtorf_w_d    = mtorf_w_q;
        alu_w_d      = alu_w_q;
        dmout_w_d    = dmout_w_q;
        rfa_w_d      = rfa_w_q;
        misalign_w_d = misalign_w_q;
        if (stall) begin
            rfwe_w_d = 1'b0;
        end else begin
            rfwe_w_d     = RFWEM;
            mtorf_w_d    = MtoRFSelM;
            alu_w_d      = ALUOutM;
            rfa_w_d      = RFAM;
            misalign_w_d = misalign;
            if (misalign) begin
                dmout_w_d = '0;
            end else if (MtoRFSelM) begin
                dmout_w_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rfwe_w_q     <= 1'b0;
            mtorf_w_q    <= 1'b0;
            alu_w_q      <= '0;
            dmout_w_q    <= '0;
            rfa_w_q      <= '0;
            misalign_w_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rfwe_w_q     <= rfwe_w_d;
            mtorf_w_q    <= mtorf_w_d;
            alu_w_q      <= alu_w_d;
            dmout_w_q    <= dmout_w_d;
            rfa_w_q      <= rfa_w_d;
            misalign_w_q <= misalign_w_d;
        end
    end

    assign StallM    = stall;
    assign RFWEW     = rfwe_w_q;
    assign MtoRFSelW = mtorf_w_q;
    assign ALUOutW   = alu_w_q;
    assign DMOutW    = dmout_w_q;
    assign RFAW      = rfa_w_q;
    assign MisalignW = misalign_w_q;

endmodule
